key_event_encoder: RTL and testbench

- Downstream of the keyboard sniffer. Consumes its modifier/keycode outputs (first key slot of the HID boot report).
- Filters report glitches with a stability counter and detects key transitions.
- Translates HID usage codes to ASCII, honouring Shift.
- Queues one byte per event in a small FIFO with a valid/ready interface toward a UART/console sink.

---
 rtl/key_event_encoder.sv | 213 +++++++++++++++++++++
 tb/tb_key_event_encoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// key_event_encoder
//   Turns the first key slot of a HID boot report into a stream of ASCII
//   bytes. A stability filter suppresses report glitches, committed key
//   changes are translated (Shift aware) and queued in a small FIFO that
//   drains through a valid/ready handshake toward a console sink.
//
//   Optional build macro: KEY_RELEASE_EN
//     When defined, replacing a mapped key also emits a release byte
//     {1'b1, unshifted ASCII of the old key} ahead of the new press.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset, clears all state
//   modifier    HID modifier byte (bit1 LShift, bit5 RShift)
//   keycode     HID usage code of the first key slot (0x00 = none)
//   ev_data     event byte at FIFO head
//   ev_valid    FIFO not empty
//   ev_ready    sink accepts; pop on ev_valid & ev_ready
//   fifo_level  current FIFO occupancy
//   overflow    sticky, an event was dropped on a full FIFO
module key_event_encoder #(
   parameter int FIFO_DEPTH    = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    modifier,
   input  logic [7:0]                    keycode,
   output logic [7:0]                    ev_data,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [STAB_W-1:0] STAB_MAX     = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [LVL_W-1:0]  LVL_FULL     = LVL_W'(FIFO_DEPTH);
   localparam logic [7:0]        KEY_NONE     = 8'h00;
   localparam logic [7:0]        KEY_ROLLOVER = 8'h01;

   // Returns {mapped, ascii}; mapped = 0 means the code produces no event.
   function automatic logic [8:0] hid_to_ascii(input logic [7:0] code, input logic shift);
      logic [8:0] r;
      r = 9'h000;
      if ((code >= 8'h04) && (code <= 8'h1D)) begin
         r = {1'b1, (shift ? 8'h41 : 8'h61) + (code - 8'h04)};
      end else if ((code >= 8'h1E) && (code <= 8'h26)) begin
         r = {1'b1, 8'h31 + (code - 8'h1E)};
      end else begin
         case (code)
            8'h27:   r = {1'b1, 8'h30};
            8'h28:   r = {1'b1, 8'h0D};
            8'h2A:   r = {1'b1, 8'h08};
            8'h2B:   r = {1'b1, 8'h09};
            8'h2C:   r = {1'b1, 8'h20};
            default: r = 9'h000;
         endcase
      end
      return r;
   endfunction

   logic [7:0]        cand_r;
   logic [STAB_W-1:0] stab_r;
   logic [7:0]        prev_key_r;
   logic [7:0]        mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [LVL_W-1:0]  level_r;
   logic              overflow_r;

   logic              shift_s;
   logic              commit_s;
   logic [8:0]        new_map_s;
   logic              press_s;
   logic              push_s;
   logic [7:0]        push_data_s;
   logic              pop_s;
   logic              full_s;
   logic              accept_s;

   // Masking keeps every modifier bit referenced; only the two Shift bits matter.
   assign shift_s   = |(modifier & 8'h22);
   assign new_map_s = hid_to_ascii(cand_r, shift_s);
   assign press_s   = commit_s && (cand_r != KEY_NONE) && new_map_s[8];

`ifdef KEY_RELEASE_EN
   logic       pend_r;
   logic [7:0] pend_data_r;
   logic [8:0] old_map_s;
   logic       release_s;

   assign old_map_s = hid_to_ascii(prev_key_r, 1'b0);
   // A pending press blocks new commits so events never reorder.
   assign commit_s  = (stab_r == STAB_MAX) && (cand_r != prev_key_r) &&
                      (cand_r != KEY_ROLLOVER) && !pend_r;
   assign release_s = commit_s && (prev_key_r != KEY_NONE) && old_map_s[8];

   // Push selection: drain the held press first, then release, then plain press.
   always_comb begin
      push_s      = 1'b0;
      push_data_s = 8'h00;
      if (pend_r) begin
         push_s      = 1'b1;
         push_data_s = pend_data_r;
      end else if (release_s) begin
         push_s      = 1'b1;
         push_data_s = {1'b1, old_map_s[6:0]};
      end else if (press_s) begin
         push_s      = 1'b1;
         push_data_s = new_map_s[7:0];
      end else begin
         push_s      = 1'b0;
         push_data_s = 8'h00;
      end
   end

   // Holds the press that follows a release by one edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_r      <= 1'b0;
         pend_data_r <= 8'h00;
      end else if (release_s && press_s) begin
         pend_r      <= 1'b1;
         pend_data_r <= new_map_s[7:0];
      end else if (pend_r) begin
         pend_r      <= 1'b0;
      end else begin
         pend_r      <= pend_r;
      end
   end
`else
   assign commit_s = (stab_r == STAB_MAX) && (cand_r != prev_key_r) &&
                     (cand_r != KEY_ROLLOVER);

   // Push selection: press events only.
   always_comb begin
      push_s      = 1'b0;
      push_data_s = 8'h00;
      if (press_s) begin
         push_s      = 1'b1;
         push_data_s = new_map_s[7:0];
      end else begin
         push_s      = 1'b0;
         push_data_s = 8'h00;
      end
   end
`endif

   assign pop_s    = (level_r != {LVL_W{1'b0}}) && ev_ready;
   assign full_s   = (level_r == LVL_FULL);
   assign accept_s = push_s && (!full_s || pop_s);

   // Stability filter and committed-key tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand_r     <= 8'h00;
         stab_r     <= {STAB_W{1'b0}};
         prev_key_r <= 8'h00;
      end else begin
         if (keycode != cand_r) begin
            cand_r <= keycode;
            stab_r <= {STAB_W{1'b0}};
         end else if (stab_r != STAB_MAX) begin
            stab_r <= stab_r + STAB_W'(1);
         end else begin
            stab_r <= stab_r;
         end
         if (commit_s) begin
            prev_key_r <= cand_r;
         end else begin
            prev_key_r <= prev_key_r;
         end
      end
   end

   // Event FIFO storage, pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         level_r    <= {LVL_W{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (accept_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({accept_s, pop_s})
            2'b10:   level_r <= level_r + LVL_W'(1);
            2'b01:   level_r <= level_r - LVL_W'(1);
            default: level_r <= level_r;
         endcase
         if (push_s && !accept_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   assign ev_data    = mem_r[rd_ptr_r];
   assign ev_valid   = (level_r != {LVL_W{1'b0}});
   assign fifo_level = level_r;
   assign overflow   = overflow_r;

endmodule

// File: tb/tb_key_event_encoder.sv
// Self-checking bench for key_event_encoder (FIFO_DEPTH 8, STABLE_CYCLES 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_event_encoder;

`ifdef KEY_RELEASE_EN
   localparam int REL = 1;
`else
   localparam int REL = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] modifier;
   logic [7:0] keycode;
   logic [7:0] ev_data;
   logic       ev_valid;
   logic       ev_ready;
   logic [3:0] fifo_level;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] mod;
      logic [7:0] key;
      logic       mapped;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs [12];
   logic [7:0] exp_q [$];

   key_event_encoder #(.FIFO_DEPTH(8), .STABLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .modifier(modifier), .keycode(keycode),
      .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .fifo_level(fifo_level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pop_expect(input string name, input logic [7:0] exp);
      chk({name, "_valid"}, {31'd0, ev_valid}, 32'd1);
      chk({name, "_data"}, {24'd0, ev_data}, {24'd0, exp});
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
   endtask

   task automatic drain_all(input string name);
      ev_ready = 1'b1;
      for (int i = 0; (i < 20) && ev_valid; i++) tick(1);
      ev_ready = 1'b0;
      chk({name, "_drained"}, {28'd0, fifo_level}, 32'd0);
   endtask

   task automatic do_reset();
      keycode  = 8'h00;
      modifier = 8'h00;
      ev_ready = 1'b0;
      rst      = 1'b0;
      tick(2);
      rst      = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{8'h00, 8'h04, 1'b1, 8'h61};
      vecs[1]  = '{8'h20, 8'h0B, 1'b1, 8'h48};
      vecs[2]  = '{8'h20, 8'h1F, 1'b1, 8'h32};
      vecs[3]  = '{8'h02, 8'h1D, 1'b1, 8'h5A};
      vecs[4]  = '{8'h00, 8'h27, 1'b1, 8'h30};
      vecs[5]  = '{8'h00, 8'h28, 1'b1, 8'h0D};
      vecs[6]  = '{8'h00, 8'h2A, 1'b1, 8'h08};
      vecs[7]  = '{8'h00, 8'h2B, 1'b1, 8'h09};
      vecs[8]  = '{8'h00, 8'h2C, 1'b1, 8'h20};
      vecs[9]  = '{8'h00, 8'h3A, 1'b0, 8'h00};
      vecs[10] = '{8'h00, 8'h29, 1'b0, 8'h00};
      vecs[11] = '{8'h22, 8'h26, 1'b1, 8'h39};

      keycode  = 8'h00;
      modifier = 8'h00;
      ev_ready = 1'b0;
      rst      = 1'b0;
      tick(1);
      chk("rst_valid", {31'd0, ev_valid}, 32'd0);
      chk("rst_data", {24'd0, ev_data}, 32'd0);
      chk("rst_level", {28'd0, fifo_level}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      rst = 1'b1;

      // First press latency: valid must rise after exactly the fifth edge.
      keycode = 8'h04;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         chk($sformatf("lat_valid_e%0d", k), {31'd0, ev_valid}, (k == 5) ? 32'd1 : 32'd0);
      end
      chk("lat_level", {28'd0, fifo_level}, 32'd1);
      chk("lat_data", {24'd0, ev_data}, 32'h61);
      keycode = 8'h00;
      tick(6);
      drain_all("lat");

      // Table of single presses.
      for (int v = 0; v < 12; v++) begin
         modifier = vecs[v].mod;
         keycode  = vecs[v].key;
         tick(6);
         keycode  = 8'h00;
         modifier = 8'h00;
         tick(6);
         chk($sformatf("vec%0d_level", v), {28'd0, fifo_level},
             vecs[v].mapped ? 32'(1 + REL) : 32'd0);
         if (vecs[v].mapped) chk($sformatf("vec%0d_data", v), {24'd0, ev_data}, {24'd0, vecs[v].exp});
         chk($sformatf("vec%0d_ovf", v), {31'd0, overflow}, 32'd0);
         drain_all($sformatf("vec%0d", v));
      end

      // Glitching keycode never stays stable long enough to commit.
      for (int i = 0; i < 10; i++) begin
         keycode = (i % 2 == 1) ? 8'h05 : 8'h04;
         tick(2);
      end
      keycode = 8'h00;
      tick(6);
      chk("toggle_level", {28'd0, fifo_level}, 32'd0);
      chk("toggle_ovf", {31'd0, overflow}, 32'd0);

      // ErrorRollOver is transparent: 04 -> 01 -> 04 yields a single press.
      keycode = 8'h04; tick(6);
      keycode = 8'h01; tick(6);
      keycode = 8'h04; tick(6);
      chk("roll_level_held", {28'd0, fifo_level}, 32'd1);
      keycode = 8'h00; tick(6);
      chk("roll_level", {28'd0, fifo_level}, 32'(1 + REL));
      chk("roll_data", {24'd0, ev_data}, 32'h61);
      drain_all("roll");

      // Direct key change without an intervening release.
      keycode = 8'h04; tick(6);
      keycode = 8'h05; tick(6);
      chk("direct_level", {28'd0, fifo_level}, 32'(2 + REL));
      pop_expect("direct0", 8'h61);
`ifdef KEY_RELEASE_EN
      pop_expect("direct_rel", 8'hE1);
`endif
      pop_expect("direct1", 8'h62);
      keycode = 8'h00; tick(6);
      drain_all("direct");

      // Nine presses into an eight-entry FIFO with the sink stalled.
      exp_q.delete();
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(8'(8'h61 + i));
`ifdef KEY_RELEASE_EN
         exp_q.push_back(8'(8'hE1 + i));
`endif
         keycode = 8'(8'h04 + i); tick(6);
         keycode = 8'h00;         tick(6);
      end
      chk("ovf_level", {28'd0, fifo_level}, 32'd8);
      chk("ovf_flag", {31'd0, overflow}, 32'd1);
      for (int k = 0; k < 8; k++) pop_expect($sformatf("ovf_pop%0d", k), exp_q[k]);
      chk("ovf_empty_valid", {31'd0, ev_valid}, 32'd0);
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);

      // Asynchronous reset in the middle of a drain.
      do_reset();
      chk("rst2_ovf", {31'd0, overflow}, 32'd0);
      keycode = 8'h04; tick(6);
      keycode = 8'h05; tick(6);
      chk("mid_level", {28'd0, fifo_level}, 32'(2 + REL));
      ev_ready = 1'b1;
      tick(1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, ev_valid}, 32'd0);
      chk("mid_rst_level", {28'd0, fifo_level}, 32'd0);
      chk("mid_rst_data", {24'd0, ev_data}, 32'd0);
      ev_ready = 1'b0;
      keycode  = 8'h00;
      tick(1);
      rst = 1'b1;
      tick(3);
      chk("post_rst_level", {28'd0, fifo_level}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
